// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns two raw, bouncy push-buttons into clean, mutually
// exclusive S/R drive plus a timed enable window for a downstream SR latch.
// Each button is synchronised, debounced and edge-detected into a sticky
// pending flag; a small FSM arbitrates the flags and plays out the window.
// Optional build macro SR_LATCH_DRIVER_TRACK_EN adds a q_model output that
// tracks the expected latch state and drops requests that would not change it.
module sr_latch_driver #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16,
    parameter int unsigned DB_W        = 5,
    parameter int unsigned PULSE_LEN   = 2,
    parameter int unsigned HOLDOFF     = 4,
    parameter int unsigned PRIORITY    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_rst,
    output logic enable,
    output logic S,
    output logic R,
    output logic busy,
`ifdef SR_LATCH_DRIVER_TRACK_EN
    output logic q_model,
`endif
    output logic conflict
);

    // Channel 0 is the set button, channel 1 the reset button.
    localparam int unsigned N_CH    = 2;
    localparam int unsigned TMR_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    logic [N_CH-1:0]        btn;
    logic [SYNC_STAGES-1:0] sync_q [N_CH];
    logic [SYNC_STAGES-1:0] sync_d [N_CH];
    logic [DB_W-1:0]        cnt_q  [N_CH];
    logic [DB_W-1:0]        cnt_d  [N_CH];
    logic [N_CH-1:0]        db_q, db_d;
    logic [N_CH-1:0]        db_prev_q, db_prev_d;
    logic [N_CH-1:0]        rise;
    logic [N_CH-1:0]        pend_q, pend_d;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   enable_q, enable_d;
    logic                   s_q, s_d;
    logic                   r_q, r_d;
    logic                   busy_q, busy_d;
    logic                   conflict_q, conflict_d;
    logic                   qm_q, qm_d;
    logic                   req_set, req_rst, both, win_set, clr;

    assign btn = {btn_rst, btn_set};

    // Synchroniser shift and per-channel debounce counter / level update.
    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], btn[ch]};
            db_d[ch]   = db_q[ch];
            cnt_d[ch]  = '0;
            if (sync_q[ch][SYNC_STAGES-1] != db_q[ch]) begin
                if (cnt_q[ch] == DB_W'(DB_CYCLES - 1)) begin
                    db_d[ch] = ~db_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + DB_W'(1);
                end
            end
        end
        db_prev_d = db_q;
    end

    // Press is a 0->1 edge of the debounced level, seen one edge after it.
    assign rise = db_q & ~db_prev_q;

    // Front-end registers: synchronisers, debounce counters and levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                sync_q[ch] <= '0;
                cnt_q[ch]  <= '0;
            end
            db_q      <= '0;
            db_prev_q <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                sync_q[ch] <= sync_d[ch];
                cnt_q[ch]  <= cnt_d[ch];
            end
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
        end
    end

    // Arbitration, window timing and next values of all registered outputs.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        enable_d   = 1'b0;
        s_d        = 1'b0;
        r_d        = 1'b0;
        busy_d     = 1'b0;
        conflict_d = 1'b0;
        qm_d       = qm_q;
        clr        = 1'b0;

`ifdef SR_LATCH_DRIVER_TRACK_EN
        // Only requests that would change the modelled latch state count.
        req_set = pend_q[0] & ~qm_q;
        req_rst = pend_q[1] &  qm_q;
`else
        req_set = pend_q[0];
        req_rst = pend_q[1];
`endif
        both    = req_set & req_rst;
        win_set = both ? (PRIORITY != 0) : req_set;

        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    clr = 1'b1;
                    if (req_set | req_rst) begin
                        state_d    = ST_DRIVE;
                        tmr_d      = TMR_W'(PULSE_LEN - 1);
                        enable_d   = 1'b1;
                        s_d        = win_set;
                        r_d        = ~win_set;
                        busy_d     = 1'b1;
                        conflict_d = both;
                        qm_d       = win_set;
                    end
                end
            end
            ST_DRIVE: begin
                if (tmr_q == '0) begin
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        tmr_d   = TMR_W'(HOLDOFF - 1);
                        busy_d  = 1'b1;
                    end
                end else begin
                    tmr_d    = tmr_q - TMR_W'(1);
                    enable_d = 1'b1;
                    s_d      = s_q;
                    r_d      = r_q;
                    busy_d   = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d  = tmr_q - TMR_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New presses always land, even on the edge that clears the flags.
        pend_d = (pend_q & ~{N_CH{clr}}) | rise;
    end

    // FSM state, pending flags and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            pend_q     <= '0;
            enable_q   <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            qm_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            pend_q     <= pend_d;
            enable_q   <= enable_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
            qm_q       <= qm_d;
        end
    end

    assign enable   = enable_q;
    assign S        = s_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
`ifdef SR_LATCH_DRIVER_TRACK_EN
    assign q_model  = qm_q;
`endif

    // Latch-safety invariants on the registered drive.
    a_no_s_and_r: assert property (@(posedge clk) disable iff (rst) !(s_q && r_q));
    a_quiet_when_disabled: assert property (@(posedge clk) disable iff (rst)
        !enable_q |-> (!s_q && !r_q));
    a_idle_not_busy: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_IDLE) |-> !busy_q);

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: two instances share the buttons, one
// with reset-wins and one with set-wins arbitration.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst;
    logic btn_set, btn_rst;
    logic en0, s0, r0, busy0, conf0;
    logic en1, s1, r1, busy1, conf1;
`ifdef SR_LATCH_DRIVER_TRACK_EN
    logic qm0, qm1;
`endif

    int checks = 0;
    int errors = 0;
    int en_cycles = 0;
    int busy_cycles = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    sr_latch_driver #(.PRIORITY(0)) dut0 (
        .clk(clk), .rst(rst), .btn_set(btn_set), .btn_rst(btn_rst),
        .enable(en0), .S(s0), .R(r0), .busy(busy0),
`ifdef SR_LATCH_DRIVER_TRACK_EN
        .q_model(qm0),
`endif
        .conflict(conf0)
    );

    sr_latch_driver #(.PRIORITY(1)) dut1 (
        .clk(clk), .rst(rst), .btn_set(btn_set), .btn_rst(btn_rst),
        .enable(en1), .S(s1), .R(r1), .busy(busy1),
`ifdef SR_LATCH_DRIVER_TRACK_EN
        .q_model(qm1),
`endif
        .conflict(conf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n edges, sampling 1ns after each and tallying activity.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (en0 || en1) en_cycles++;
            if (busy0 || busy1) busy_cycles++;
            if ((s0 && r0) || (s1 && r1)) overlap++;
        end
    endtask

    // Called just after the edge that enters DRIVE; walks the whole window.
    task automatic check_window(input string tag, input logic es0, input logic er0,
                                input logic es1, input logic er1, input logic ec);
        check({tag, "_d0_dut0"}, 32'({en0, s0, r0, busy0, conf0}), 32'({1'b1, es0, er0, 1'b1, ec}));
        check({tag, "_d0_dut1"}, 32'({en1, s1, r1, busy1, conf1}), 32'({1'b1, es1, er1, 1'b1, ec}));
        step(1);
        check({tag, "_d1_dut0"}, 32'({en0, s0, r0, busy0, conf0}), 32'({1'b1, es0, er0, 1'b1, 1'b0}));
        check({tag, "_d1_dut1"}, 32'({en1, s1, r1, busy1, conf1}), 32'({1'b1, es1, er1, 1'b1, 1'b0}));
        step(1);
        check({tag, "_hold_start"}, 32'({en0, s0, r0, busy0, en1, s1, r1, busy1}), 32'(8'b0001_0001));
        step(3);
        check({tag, "_hold_end"}, 32'({busy0, busy1}), 32'(2'b11));
        step(1);
        check({tag, "_idle"}, 32'({en0, busy0, en1, busy1}), 32'(4'b0000));
    endtask

    // Drop both buttons and confirm the releases produce nothing.
    task automatic release_all(input string tag);
        btn_set   = 1'b0;
        btn_rst   = 1'b0;
        en_cycles = 0;
        step(30);
        check({tag, "_release_quiet"}, 32'(en_cycles), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        btn_set = 1'b1;
        btn_rst = 1'b1;

        // Reset held with both buttons high.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold", 32'({en0, s0, r0, busy0, conf0, en1, s1, r1, busy1, conf1}), 32'(0));
        end
        rst = 1'b0;
        en_cycles = 0;
        step(1);
        check("rst_release", 32'({en0, s0, r0, busy0, conf0, en1, s1, r1, busy1, conf1}), 32'(0));
        // 2 sync + 16 debounce + pending + drive: DRIVE entered on the 20th edge.
        step(18);
        check("rst_no_early_drive", 32'(en_cycles), 32'(0));
        step(1);
`ifdef SR_LATCH_DRIVER_TRACK_EN
        check_window("rst_both", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("trk_q_after_set", 32'({qm0, qm1}), 32'(2'b11));
`else
        check_window("rst_both", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
`endif
        release_all("rst_both");

`ifdef SR_LATCH_DRIVER_TRACK_EN
        // Second set press is redundant: no window at all.
        en_cycles = 0;
        btn_set = 1'b1;
        step(25);
        check("trk_set_dropped", 32'(en_cycles), 32'(0));
        check("trk_q_still_set", 32'({qm0, qm1, conf0, conf1}), 32'(4'b1100));
        release_all("trk_set");

        // Reset press drives R and clears q_model.
        en_cycles = 0;
        btn_rst = 1'b1;
        step(19);
        check("trk_rst_early", 32'(en_cycles), 32'(0));
        step(1);
        check("trk_q_cleared", 32'({qm0, qm1}), 32'(2'b00));
        check_window("trk_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        release_all("trk_rst");
`else
        // Clean set press.
        en_cycles = 0;
        busy_cycles = 0;
        btn_set = 1'b1;
        step(19);
        check("set_early", 32'(en_cycles), 32'(0));
        step(1);
        check_window("set", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("set_busy_len", 32'(busy_cycles), 32'(6));
        release_all("set");

        // Bounce: toggle every 5 cycles for 60 cycles, then settle low.
        en_cycles = 0;
        busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            btn_set = ~btn_set;
            step(5);
        end
        step(30);
        check("bounce_no_enable", 32'(en_cycles), 32'(0));
        check("bounce_no_busy", 32'(busy_cycles), 32'(0));

        // Simultaneous presses from idle.
        en_cycles = 0;
        btn_set = 1'b1;
        btn_rst = 1'b1;
        step(19);
        check("both_early", 32'(en_cycles), 32'(0));
        step(1);
        check_window("both", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        release_all("both");

        // Reset press debounces during the set window and is queued.
        overlap = 0;
        en_cycles = 0;
        btn_set = 1'b1;
        step(2);
        btn_rst = 1'b1;
        step(17);
        check("queued_early", 32'(en_cycles), 32'(0));
        step(1);
        check_window("queued_set", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        check_window("queued_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("queued_no_overlap", 32'(overlap), 32'(0));
        release_all("queued");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
